// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Tracks register writes that are in flight between decode (issue) and
//   writeback. Each architectural register r != 0 has a small pending-write
//   counter. Issue increments the counter and a retiring writeback
//   decrements it. The decode stage's source-operand queries are answered
//   from these counters to produce the pipeline stall.
//
// Ports
//   clk                  core clock
//   n_reset              asynchronous active-low reset
//   dec_op_src1_i/2_i    decode source operand specifiers
//   issue_valid_i        decode holds a valid instruction attempting issue
//   issue_we_i           issuing instruction writes a register
//   issue_dest_i         issuing instruction's destination
//   wb_valid_i           writeback retires a register write this cycle
//   wb_dest_i            retiring destination
//   net_reg_write_cmd_i  network owns the register file write port this cycle
//   pipeline_stall_o     hold decode (combinational)
//   issue_fire_o         issue accepted this cycle
//   busy_vec_o           bit r set while register r has pending writes
//   err_o                sticky underflow/overflow flag
//
// Optional feature (macro SCOREBOARD_STALL_STATS_EN)
//   stats_clr_i          synchronous clear of the stall counter
//   stall_cycles_o       saturating count of cycles with pipeline_stall_o high
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int REG_WIDTH = 6,
  parameter int MAX_PEND  = 3,
  parameter int CNT_W     = 2
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [REG_WIDTH-1:0]    dec_op_src1_i,
  input  logic [REG_WIDTH-1:0]    dec_op_src2_i,
  input  logic                    issue_valid_i,
  input  logic                    issue_we_i,
  input  logic [REG_WIDTH-1:0]    issue_dest_i,
  input  logic                    wb_valid_i,
  input  logic [REG_WIDTH-1:0]    wb_dest_i,
  input  logic                    net_reg_write_cmd_i,
  output logic                    pipeline_stall_o,
  output logic                    issue_fire_o,
  output logic [2**REG_WIDTH-1:0] busy_vec_o,
  output logic                    err_o
`ifdef SCOREBOARD_STALL_STATS_EN
  ,
  input  logic                    stats_clr_i,
  output logic [31:0]             stall_cycles_o
`endif
);

  localparam int NREG = 2**REG_WIDTH;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CNT_W-1:0] count_q [NREG];
  logic [CNT_W-1:0] count_d [NREG];
  logic             err_q, err_d;

  logic haz1, haz2, ovf_guard, wb_hits_dest, stall, fire;

  // A final writeback in the same cycle releases the operand: the register
  // file writes before it is read.
  assign haz1 = (dec_op_src1_i != '0) && (count_q[dec_op_src1_i] != '0) &&
                !(wb_valid_i && (wb_dest_i == dec_op_src1_i) &&
                  (count_q[dec_op_src1_i] == ONE_CNT));
  assign haz2 = (dec_op_src2_i != '0) && (count_q[dec_op_src2_i] != '0) &&
                !(wb_valid_i && (wb_dest_i == dec_op_src2_i) &&
                  (count_q[dec_op_src2_i] == ONE_CNT));

  // A full counter may still accept an issue when a writeback to the same
  // register frees a slot in this very cycle (count stays unchanged).
  assign wb_hits_dest = wb_valid_i && (wb_dest_i == issue_dest_i);
  assign ovf_guard    = issue_we_i && (issue_dest_i != '0) &&
                        (count_q[issue_dest_i] == MAX_CNT) && !wb_hits_dest;

  assign stall = issue_valid_i && (haz1 || haz2 || ovf_guard || net_reg_write_cmd_i);
  assign fire  = issue_valid_i && !stall;

  assign pipeline_stall_o = stall;
  assign issue_fire_o     = fire;
  assign err_o            = err_q;

  always_comb begin : next_state
    logic inc_l, dec_l;
    inc_l = 1'b0;
    dec_l = 1'b0;
    err_d = err_q;
    count_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      count_d[r] = count_q[r];
      inc_l = fire && issue_we_i && (issue_dest_i == REG_WIDTH'(r));
      dec_l = wb_valid_i && (wb_dest_i == REG_WIDTH'(r)) && (count_q[r] != '0);
      // Writeback with nothing pending: counter stays at zero, flag it.
      if (wb_valid_i && (wb_dest_i == REG_WIDTH'(r)) && (count_q[r] == '0))
        err_d = 1'b1;
      if (inc_l && !dec_l) begin
        if (count_q[r] == MAX_CNT)
          err_d = 1'b1;
        else
          count_d[r] = count_q[r] + ONE_CNT;
      end else if (dec_l && !inc_l) begin
        count_d[r] = count_q[r] - ONE_CNT;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int r = 0; r < NREG; r++) count_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) count_q[r] <= count_d[r];
      err_q <= err_d;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    assign busy_vec_o[gi] = (count_q[gi] != '0);
  end

`ifdef SCOREBOARD_STALL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stats_clr_i)
      stall_cycles_d = '0;
    else if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) stall_cycles_q <= '0;
    else          stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  localparam int RW   = 6;
  localparam int NREG = 2**RW;

  logic            clk = 1'b0;
  logic            n_reset;
  logic [RW-1:0]   src1, src2, idest, wdest;
  logic            ivalid, iwe, wvalid, net;
  logic            stall, fire, err;
  logic [NREG-1:0] busy;
`ifdef SCOREBOARD_STALL_STATS_EN
  logic            stats_clr;
  logic [31:0]     stall_cycles;
`endif

  reg_scoreboard #(.REG_WIDTH(RW), .MAX_PEND(3), .CNT_W(2)) dut (
    .clk                 (clk),
    .n_reset             (n_reset),
    .dec_op_src1_i       (src1),
    .dec_op_src2_i       (src2),
    .issue_valid_i       (ivalid),
    .issue_we_i          (iwe),
    .issue_dest_i        (idest),
    .wb_valid_i          (wvalid),
    .wb_dest_i           (wdest),
    .net_reg_write_cmd_i (net),
    .pipeline_stall_o    (stall),
    .issue_fire_o        (fire),
    .busy_vec_o          (busy),
    .err_o               (err)
`ifdef SCOREBOARD_STALL_STATS_EN
    ,
    .stats_clr_i         (stats_clr),
    .stall_cycles_o      (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=%0h expected=<none>", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
    $display("check %-14s observed=%0h expected=%0h", e.tag, obs, e.exp);
  endtask

  // Expect stall/fire for the currently driven inputs.
  task automatic chk_sf(input string tag, input logic s, input logic f);
    push({tag, "_stall"}, 64'(s)); pop_chk(64'(stall));
    push({tag, "_fire"},  64'(f)); pop_chk(64'(fire));
  endtask

  task automatic chk_busy(input string tag, input logic [63:0] b);
    push({tag, "_busy"}, b); pop_chk(64'(busy));
  endtask

  task automatic drive(input logic v, input logic we, input int d,
                       input int s1, input int s2,
                       input logic wv, input int wd, input logic n);
    ivalid = v;  iwe = we;  idest = RW'(d);
    src1 = RW'(s1);  src2 = RW'(s2);
    wvalid = wv;  wdest = RW'(wd);  net = n;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  // Advance past the next rising edge; leaves time 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] bexp;

  initial begin
    n_reset = 1'b0;
`ifdef SCOREBOARD_STALL_STATS_EN
    stats_clr = 1'b0;
`endif
    idle();
    #10;
    chk_busy("reset", 64'd0);
    push("reset_err", 64'd0); pop_chk(64'(err));
    chk_sf("reset", 1'b0, 1'b0);
    n_reset = 1'b1;
    tick();

    // Issue write to r5; busy from next cycle.
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    chk_sf("issue_r5", 1'b0, 1'b1);
    chk_busy("issue_r5_same", 64'd0);
    tick();
    bexp = 64'd1 << 5;
    idle();
    chk_busy("r5_busy", bexp);
    drive(1, 0, 0, 5, 0, 0, 0, 0);
    chk_sf("src1_r5", 1'b1, 1'b0);
    drive(1, 0, 0, 0, 5, 0, 0, 0);
    chk_sf("src2_r5", 1'b1, 1'b0);
    tick();
    // Final writeback releases hazard in same cycle.
    drive(1, 0, 0, 5, 0, 1, 5, 0);
    chk_sf("wb_rel_r5", 1'b0, 1'b1);
    chk_busy("wb_r5_same", bexp);
    tick();
    idle();
    chk_busy("r5_clear", 64'd0);

    // Zero sources and dest 0.
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk_sf("dest0", 1'b0, 1'b1);
    tick();
    idle();
    chk_busy("dest0_after", 64'd0);

    // Three issues to r7, then overflow guard.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 7, 0, 0, 0, 0, 0);
      chk_sf("issue_r7", 1'b0, 1'b1);
      tick();
    end
    bexp = 64'd1 << 7;
    drive(1, 1, 7, 0, 0, 0, 0, 0);
    chk_sf("r7_full", 1'b1, 1'b0);
    chk_busy("r7_busy", bexp);
    drive(1, 1, 7, 0, 0, 1, 7, 0);
    chk_sf("r7_full_wb", 1'b0, 1'b1);
    tick();
    drive(1, 1, 7, 0, 0, 0, 0, 0);
    chk_sf("r7_still3", 1'b1, 1'b0);
    // Writeback not final: hazard remains.
    drive(1, 0, 0, 7, 0, 1, 7, 0);
    chk_sf("r7_wb_notfin", 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1, 7, 0);
      tick();
    end
    drive(1, 0, 0, 0, 7, 1, 7, 0);
    chk_sf("r7_wb_final", 1'b0, 1'b1);
    tick();
    idle();
    chk_busy("r7_drained", 64'd0);
    push("no_err", 64'd0); pop_chk(64'(err));

    // Network write port conflict.
    drive(1, 1, 3, 0, 0, 0, 0, 1);
    chk_sf("net_stall", 1'b1, 1'b0);
    tick();
    idle();
    chk_busy("net_nochg", 64'd0);
    drive(0, 1, 3, 0, 0, 0, 0, 1);
    chk_sf("net_novalid", 1'b0, 1'b0);
    tick();

    // Underflow: writeback to idle r9.
    drive(0, 0, 0, 0, 0, 1, 9, 0);
    push("err_pre", 64'd0); pop_chk(64'(err));
    tick();
    idle();
    push("err_set", 64'd1); pop_chk(64'(err));
    chk_busy("underflow", 64'd0);
    tick();
    push("err_sticky", 64'd1); pop_chk(64'(err));

`ifdef SCOREBOARD_STALL_STATS_EN
    // Make r20 busy, then stall on it.
    drive(1, 1, 20, 0, 0, 0, 0, 0);
    tick();
    stats_clr = 1'b1;
    drive(1, 0, 0, 20, 0, 0, 0, 0);
    tick();
    stats_clr = 1'b0;
    push("stats_clr0", 64'd0); pop_chk(64'(stall_cycles));
    for (int i = 0; i < 4; i++) tick();
    push("stats_4", 64'd4); pop_chk(64'(stall_cycles));
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    push("stats_clr", 64'd0); pop_chk(64'(stall_cycles));
    idle();
`endif

    // Async reset mid-cycle with pending state.
    drive(1, 1, 12, 0, 0, 0, 0, 0);
    tick();
    idle();
    bexp = 64'd1 << 12;
`ifdef SCOREBOARD_STALL_STATS_EN
    bexp = bexp | (64'd1 << 20);
`endif
    chk_busy("pre_rst", bexp);
    n_reset = 1'b0;
    #1;
    chk_busy("async_rst", 64'd0);
    push("async_rst_err", 64'd0); pop_chk(64'(err));
    #5;
    n_reset = 1'b1;
    tick();
    drive(1, 0, 0, 12, 0, 0, 0, 0);
    chk_sf("post_rst", 1'b0, 1'b1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
